// File: rtl/wb_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_slave_pkg
// Brief    : Shared types and constants for the wb_slave_mem responder.
// Revision : 1.0 - initial release
// ============================================================================
package wb_slave_pkg;

    localparam int c_BYTE_GRANULE = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TERM_ACK = 2'd0,
        TERM_ERR = 2'd1,
        TERM_RTY = 2'd2
    } term_t;

endpackage
`default_nettype wire

// File: rtl/wb_slave_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : wb_slave_mem_array
// Brief    : DEPTH x DATA_WIDTH synchronous RAM, byte-enable write, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module wb_slave_mem_array
    import wb_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_wr_en,
    input  logic [DATA_WIDTH/c_BYTE_GRANULE-1:0] i_wr_be,
    input  logic [$clog2(DEPTH)-1:0]             i_addr,
    input  logic [DATA_WIDTH-1:0]                i_wr_data,
    input  logic                                 i_rd_en,
    output logic [DATA_WIDTH-1:0]                o_rd_data
);

    localparam int c_NB = DATA_WIDTH / c_BYTE_GRANULE;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int i = 0; i < c_NB; i++) begin
                if (i_wr_be[i]) begin
                    r_mem[i_addr][i*c_BYTE_GRANULE +: c_BYTE_GRANULE] <=
                        i_wr_data[i*c_BYTE_GRANULE +: c_BYTE_GRANULE];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/wb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : wb_slave_mem
// Brief    : Wishbone B4 classic-cycle slave with internal memory, configurable
//            wait states and periodic retry injection.
// Revision : 1.0 - initial release
// ============================================================================
module wb_slave_mem
    import wb_slave_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int TAG_WIDTH   = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int RTY_EVERY_N = 0
) (
    input  logic                                 CLK_I,
    input  logic                                 RST_I,
    input  logic                                 CYC_I,
    input  logic                                 STB_I,
    input  logic                                 WE_I,
    input  logic [ADDR_WIDTH-1:0]                ADR_I,
    input  logic [DATA_WIDTH-1:0]                DAT_I,
    input  logic [DATA_WIDTH/c_BYTE_GRANULE-1:0] SEL_I,
    input  logic                                 LOCK_I,
    input  logic [TAG_WIDTH-1:0]                 TGA_I,
    input  logic [TAG_WIDTH-1:0]                 TGC_I,
    input  logic [TAG_WIDTH-1:0]                 TGD_I,
    output logic [DATA_WIDTH-1:0]                DAT_O,
    output logic [TAG_WIDTH-1:0]                 TGD_O,
    output logic                                 ACK_O,
    output logic                                 ERR_O,
    output logic                                 RTY_O
);

    localparam int c_NB    = DATA_WIDTH / c_BYTE_GRANULE;
    localparam int c_OFF   = $clog2(c_NB);
    localparam int c_IDX_W = ADDR_WIDTH - c_OFF;
    localparam int c_AW    = $clog2(DEPTH);
    localparam logic [c_IDX_W-1:0] c_DEPTH_IDX = c_IDX_W'(DEPTH);

    state_t                 r_state, w_next_state;
    logic [3:0]             r_wait_cnt;
    logic                   r_we;
    logic [c_AW-1:0]        r_addr;
    logic [DATA_WIDTH-1:0]  r_dat;
    logic [c_NB-1:0]        r_sel;
    logic [TAG_WIDTH-1:0]   r_tgd;
    term_t                  r_term;
    logic                   r_ack, r_err, r_rty;
    logic [TAG_WIDTH-1:0]   r_tgd_o;

    logic                   w_idle, w_accept, w_enter_resp, w_rty_slot, w_oor;
    logic [c_IDX_W-1:0]     w_adr_idx;
    term_t                  w_acc_term, w_req_term;
    logic                   w_req_we;
    logic [c_AW-1:0]        w_req_addr;
    logic [DATA_WIDTH-1:0]  w_req_dat;
    logic [c_NB-1:0]        w_req_sel;
    logic [TAG_WIDTH-1:0]   w_req_tgd;
    logic                   w_unused;

    assign w_unused  = ^{TGA_I, TGC_I, ADR_I};
    assign w_adr_idx = ADR_I[ADDR_WIDTH-1:c_OFF];
    assign w_oor     = (w_adr_idx >= c_DEPTH_IDX);
    assign w_idle    = (r_state == ST_IDLE);
    assign w_accept  = w_idle && CYC_I && STB_I;

    generate
        if (RTY_EVERY_N > 0) begin : g_rty
            localparam int c_RW = $clog2(RTY_EVERY_N + 1);
            logic [c_RW-1:0] r_rty_cnt;
            logic            w_wrap;

            assign w_wrap     = (r_rty_cnt == c_RW'(RTY_EVERY_N - 1));
            assign w_rty_slot = w_accept && !LOCK_I && w_wrap;

            always_ff @(posedge CLK_I) begin
                if (RST_I) begin
                    r_rty_cnt <= '0;
                end else if (w_accept && !LOCK_I) begin
                    r_rty_cnt <= w_wrap ? '0 : r_rty_cnt + 1'b1;
                end
            end
        end else begin : g_no_rty
            assign w_rty_slot = 1'b0;
        end
    endgenerate

    always_comb begin
        w_acc_term = TERM_ACK;
        if (w_oor) begin
            w_acc_term = TERM_ERR;
        end else if (w_rty_slot) begin
            w_acc_term = TERM_RTY;
        end
    end

    // A zero-wait request enters RESP straight from IDLE, so use live inputs then.
    assign w_req_term = w_idle ? w_acc_term : r_term;
    assign w_req_we   = w_idle ? WE_I : r_we;
    assign w_req_addr = w_idle ? w_adr_idx[c_AW-1:0] : r_addr;
    assign w_req_dat  = w_idle ? DAT_I : r_dat;
    assign w_req_sel  = w_idle ? SEL_I : r_sel;
    assign w_req_tgd  = w_idle ? TGD_I : r_tgd;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_enter_resp = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_next_state = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!(CYC_I && STB_I)) begin
                    w_next_state = ST_IDLE;
                end else if (r_wait_cnt == 4'd0) begin
                    w_next_state = ST_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_wait_cnt <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_dat      <= '0;
            r_sel      <= '0;
            r_tgd      <= '0;
            r_term     <= TERM_ACK;
        end else if (w_accept) begin
            r_wait_cnt <= 4'(WAIT_STATES - 1);
            r_we       <= WE_I;
            r_addr     <= w_adr_idx[c_AW-1:0];
            r_dat      <= DAT_I;
            r_sel      <= SEL_I;
            r_tgd      <= TGD_I;
            r_term     <= w_acc_term;
        end else if (r_state == ST_WAIT && r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rty   <= 1'b0;
            r_tgd_o <= '0;
        end else begin
            r_ack <= w_enter_resp && (w_req_term == TERM_ACK);
            r_err <= w_enter_resp && (w_req_term == TERM_ERR);
            r_rty <= w_enter_resp && (w_req_term == TERM_RTY);
            if (w_enter_resp) begin
                r_tgd_o <= w_req_tgd;
            end
        end
    end

    wb_slave_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk       (CLK_I),
        .rst       (RST_I),
        .i_wr_en   (w_enter_resp && w_req_we && (w_req_term == TERM_ACK) && !RST_I),
        .i_wr_be   (w_req_sel),
        .i_addr    (w_req_addr),
        .i_wr_data (w_req_dat),
        .i_rd_en   (w_enter_resp && !w_req_we && (w_req_term == TERM_ACK)),
        .o_rd_data (DAT_O)
    );

    assign TGD_O = r_tgd_o;
    assign ACK_O = r_ack;
    assign ERR_O = r_err;
    assign RTY_O = r_rty;

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_slave_mem
// Brief    : Self-checking bench for wb_slave_mem across three configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_slave_mem;

    localparam int         c_NDUT = 3;
    localparam logic [2:0] c_ACK  = 3'b001;
    localparam logic [2:0] c_ERR  = 3'b010;
    localparam logic [2:0] c_RTY  = 3'b100;

    typedef struct {
        int          dut;
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          lock;
        logic [7:0]  tgd;
        logic [2:0]  term;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        logic [2:0]  term;
        int          lat;
        logic [7:0]  tgd;
        logic [31:0] rd;
        bit          chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we, lock;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic [7:0]  tgd;
    int          tsel;
    logic [2:0]  cyc_v;
    logic [31:0] dat_o [c_NDUT];
    logic [7:0]  tgd_o [c_NDUT];
    logic [2:0]  ack_o, err_o, rty_o;
    logic [7:0]  zero_tag = 8'h00;

    int   total = 0;
    int   bad   = 0;
    int   ws [c_NDUT];
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    assign cyc_v[0] = cyc && (tsel == 0);
    assign cyc_v[1] = cyc && (tsel == 1);
    assign cyc_v[2] = cyc && (tsel == 2);

    wb_slave_mem #(.WAIT_STATES(0), .RTY_EVERY_N(0)) u0 (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc_v[0]), .STB_I(stb), .WE_I(we),
        .ADR_I(adr), .DAT_I(dat), .SEL_I(sel), .LOCK_I(lock),
        .TGA_I(zero_tag), .TGC_I(zero_tag), .TGD_I(tgd),
        .DAT_O(dat_o[0]), .TGD_O(tgd_o[0]),
        .ACK_O(ack_o[0]), .ERR_O(err_o[0]), .RTY_O(rty_o[0]));

    wb_slave_mem #(.WAIT_STATES(3), .RTY_EVERY_N(0)) u1 (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc_v[1]), .STB_I(stb), .WE_I(we),
        .ADR_I(adr), .DAT_I(dat), .SEL_I(sel), .LOCK_I(lock),
        .TGA_I(zero_tag), .TGC_I(zero_tag), .TGD_I(tgd),
        .DAT_O(dat_o[1]), .TGD_O(tgd_o[1]),
        .ACK_O(ack_o[1]), .ERR_O(err_o[1]), .RTY_O(rty_o[1]));

    wb_slave_mem #(.WAIT_STATES(0), .RTY_EVERY_N(3)) u2 (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc_v[2]), .STB_I(stb), .WE_I(we),
        .ADR_I(adr), .DAT_I(dat), .SEL_I(sel), .LOCK_I(lock),
        .TGA_I(zero_tag), .TGC_I(zero_tag), .TGD_I(tgd),
        .DAT_O(dat_o[2]), .TGD_O(tgd_o[2]),
        .ACK_O(ack_o[2]), .ERR_O(err_o[2]), .RTY_O(rty_o[2]));

    function automatic logic [2:0] term_of(input int k);
        return {rty_o[k], err_o[k], ack_o[k]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input int d, input bit w, input logic [31:0] a,
                                input logic [31:0] dt, input logic [3:0] s, input bit lk,
                                input logic [7:0] tg, input logic [2:0] t,
                                input logic [31:0] r);
        vec_t v;
        v.dut = d; v.we = w; v.adr = a; v.dat = dt; v.sel = s; v.lock = lk;
        v.tgd = tg; v.term = t; v.rd = r;
        vecs.push_back(v);
    endfunction

    // One classic cycle: expectation queued at drive time, popped on termination.
    task automatic xfer(input string tag, input vec_t v);
        exp_t       e;
        int         lat;
        bit         seen;
        logic [2:0] t;
        e.term = v.term; e.lat = ws[v.dut] + 1; e.tgd = v.tgd; e.rd = v.rd; e.chk = !v.we;
        sb.push_back(e);
        tsel = v.dut; we = v.we; adr = v.adr; dat = v.dat; sel = v.sel;
        lock = v.lock; tgd = v.tgd; cyc = 1'b1; stb = 1'b1;
        lat = 0; seen = 0; t = 3'b000;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            t = term_of(v.dut);
            if (t != 3'b000) seen = 1;
        end
        cyc = 1'b0; stb = 1'b0;
        e = sb.pop_front();
        check({tag, "_term"}, 32'(t), 32'(e.term));
        check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        check({tag, "_tgd"}, 32'(tgd_o[v.dut]), 32'(e.tgd));
        if (e.chk) check({tag, "_dat"}, dat_o[v.dut], e.rd);
        @(posedge clk); #1;
        check({tag, "_width"}, 32'(term_of(v.dut)), 32'h0);
    endtask

    initial begin
        vec_t v;
        bit   seen;
        ws[0] = 0; ws[1] = 3; ws[2] = 0;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; lock = 1'b0;
        adr = '0; dat = '0; sel = '0; tgd = '0; tsel = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < c_NDUT; k++) begin
            check($sformatf("reset_term%0d", k), 32'(term_of(k)), 32'h0);
            check($sformatf("reset_dat%0d", k), dat_o[k], 32'h0);
            check($sformatf("reset_tgd%0d", k), 32'(tgd_o[k]), 32'h0);
        end

        // Zero-wait responder: basic, byte lanes, out of range, boundaries, tag.
        add(0, 1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 8'h01, c_ACK, 32'h0);
        add(0, 0, 32'h10,  32'h0,        4'hF, 0, 8'h02, c_ACK, 32'hDEADBEEF);
        add(0, 1, 32'h20,  32'h11223344, 4'hF, 0, 8'h03, c_ACK, 32'h0);
        add(0, 1, 32'h20,  32'hAABBCCDD, 4'h5, 0, 8'h04, c_ACK, 32'h0);
        add(0, 0, 32'h20,  32'h0,        4'hF, 0, 8'h05, c_ACK, 32'h11BB33DD);
        add(0, 1, 32'h0,   32'h01020304, 4'hF, 0, 8'h06, c_ACK, 32'h0);
        add(0, 1, 32'h400, 32'h12345678, 4'hF, 0, 8'h07, c_ERR, 32'h0);
        add(0, 0, 32'h400, 32'h0,        4'hF, 0, 8'h08, c_ERR, 32'h11BB33DD);
        add(0, 0, 32'h0,   32'h0,        4'hF, 0, 8'h09, c_ACK, 32'h01020304);
        add(0, 1, 32'h3FC, 32'hCAFEF00D, 4'hF, 0, 8'h0A, c_ACK, 32'h0);
        add(0, 0, 32'h3FF, 32'h0,        4'hF, 0, 8'h0B, c_ACK, 32'hCAFEF00D);
        add(0, 0, 32'h10,  32'h0,        4'hF, 0, 8'h5A, c_ACK, 32'hDEADBEEF);
        // Three-wait responder.
        add(1, 1, 32'h40,  32'h55AA55AA, 4'hF, 0, 8'h21, c_ACK, 32'h0);
        add(1, 1, 32'h44,  32'h13572468, 4'hF, 0, 8'h22, c_ACK, 32'h0);
        add(1, 0, 32'h40,  32'h0,        4'hF, 0, 8'h23, c_ACK, 32'h55AA55AA);
        add(1, 1, 32'h800, 32'h0,        4'hF, 0, 8'h24, c_ERR, 32'h0);
        // Retry every 3rd unlocked accept; locked cycles never counted.
        for (int i = 0; i < 6; i++)
            add(2, 1, 32'(4*i), 32'hF0F0F0F0 + 32'(i), 4'hF, 1, 8'(8'h30 + i), c_ACK, 32'h0);
        for (int i = 0; i < 6; i++)
            add(2, 1, 32'(4*i), 32'h100 + 32'(i), 4'hF, 0, 8'(8'h40 + i),
                (i == 2 || i == 5) ? c_RTY : c_ACK, 32'h0);
        for (int i = 0; i < 6; i++)
            add(2, 0, 32'(4*i), 32'h0, 4'hF, 1, 8'(8'h50 + i), c_ACK,
                (i == 2 || i == 5) ? 32'hF0F0F0F0 + 32'(i) : 32'h100 + 32'(i));

        for (int i = 0; i < vecs.size(); i++) xfer($sformatf("v%0d", i), vecs[i]);

        // Strobe dropped in the second wait cycle: no termination, no write.
        tsel = 1; we = 1'b1; adr = 32'h40; dat = 32'h0BADF00D; sel = 4'hF;
        lock = 1'b0; tgd = 8'h66; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        stb = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (term_of(1) != 3'b000) seen = 1;
        end
        cyc = 1'b0;
        check("abort_no_term", 32'(seen), 32'h0);
        v.dut = 1; v.we = 0; v.adr = 32'h40; v.dat = 0; v.sel = 4'hF; v.lock = 0;
        v.tgd = 8'h67; v.term = c_ACK; v.rd = 32'h55AA55AA;
        xfer("abort_read", v);

        // Reset during the wait phase of a write drops it.
        tsel = 1; we = 1'b1; adr = 32'h44; dat = 32'hFFFF0000; sel = 4'hF;
        lock = 1'b0; tgd = 8'h77; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        check("rst_term", 32'(term_of(1)), 32'h0);
        check("rst_dat", dat_o[1], 32'h0);
        check("rst_tgd", 32'(tgd_o[1]), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        v.dut = 1; v.we = 0; v.adr = 32'h44; v.dat = 0; v.sel = 4'hF; v.lock = 0;
        v.tgd = 8'h5A; v.term = c_ACK; v.rd = 32'h13572468;
        xfer("rst_read", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
